// File: rtl/io_pkg.sv
// Shared constants for the board I/O panel: 7-segment glyphs, cathode bit
// positions and the all-off drive values for the active-low display pins.
package io_pkg;

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [7:0] CAT_OFF = 8'hFF;

  localparam int unsigned SEG_DP = 7;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_A  = 0;

  // Active-high gfedcba glyphs for hex digits 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low 7-segment cathode pattern; decimal point always dark.
module seg_hex_decode
  import io_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] cat
);

  always_comb begin
    cat                = CAT_OFF;
    cat[SEG_G:SEG_A]   = ~SEG_HEX[nibble];
  end

endmodule

// File: rtl/io_panel.sv
// Board-side DMEM I/O: debounced switch word out to the CPU, and the CPU's
// result word shown on a 4-digit multiplexed 7-segment display.
module io_panel
  import io_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] result,
  input  logic [15:0] sw,
  output logic [15:0] opr,
  output logic [3:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned DB_W   = $clog2(DB_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

  logic [15:0]       sw_meta;
  logic [15:0]       sw_s;
  logic [15:0]       cand;
  logic [DB_W-1:0]   db_cnt;

  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_wrap;
  logic [1:0]        idx;
  logic [15:0]       frame;
  logic [3:0]        nibble;
  logic [3:0]        an_next;
  logic [7:0]        cat_next;

  // Whole-vector debounce: opr only ever takes a vector that sat unchanged
  // for DB_CYCLES; the counter saturates so it cannot wrap into a false update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= '0;
      sw_s    <= '0;
      cand    <= '0;
      db_cnt  <= '0;
      opr     <= '0;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
      if (sw_s != cand) begin
        cand   <= sw_s;
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        opr    <= cand;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign scan_wrap = (scan_cnt == SCAN_LAST);

  // Frame snapshot on the 3->0 index wrap keeps each displayed frame tear-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      frame    <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= idx + 1'b1;
      if (idx == 2'd3) frame <= result;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign nibble = frame[{idx, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .nibble (nibble),
    .cat    (cat_next)
  );

  always_comb begin
    an_next      = AN_OFF;
    an_next[idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_an  <= AN_OFF;
      seg_cat <= CAT_OFF;
    end else begin
      seg_an  <= an_next;
      seg_cat <= cat_next;
    end
  end

endmodule
